// File: rtl/nco_bank.sv
// nco_bank: NUM_CH phase-accumulator oscillators with double-buffered increment/offset and LUT sin/cos.
// Build option NCO_DITHER_EN adds LFSR phase dither ahead of LUT index truncation.
module nco_bank #(
   parameter int  NUM_CH  = 4,
   parameter int  PHASE_W = 32,
   parameter int  OUT_W   = 16,
   parameter int  LUT_AW  = 10,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_CH-1:0]         en_i,
   input  logic                      cfg_valid_i,
   output logic                      cfg_ready_o,
   input  logic [CH_W-1:0]           cfg_ch_i,
   input  logic                      cfg_sel_i,
   input  logic [PHASE_W-1:0]        cfg_data_i,
   input  logic                      commit_i,
   input  logic                      commit_clr_i,
   output logic [NUM_CH-1:0]         valid_o,
   output logic [NUM_CH*OUT_W-1:0]   sin_o,
   output logic [NUM_CH*OUT_W-1:0]   cos_o
);

   localparam int  ROM_N  = 1 << LUT_AW;
   localparam int  QTR    = ROM_N / 4;
   localparam int  SHIFT  = PHASE_W - LUT_AW;
   localparam real TWO_PI = 6.283185307179586;

   function automatic logic signed [OUT_W-1:0] rom_entry(input int k);
      real amp;
      real x;
      int  r;
      amp = real'((2 ** (OUT_W - 1)) - 1);
      x   = amp * $sin(TWO_PI * real'(k) / real'(ROM_N));
      if (x >= 0.0) begin
         r = $rtoi(x + 0.5);
      end else begin
         r = -$rtoi(0.5 - x);
      end
      return OUT_W'(r);
   endfunction

   logic signed [OUT_W-1:0] rom_s [ROM_N];

   for (genvar k = 0; k < ROM_N; k++) begin : g_rom
      assign rom_s[k] = rom_entry(k);
   end

   logic                      cfg_ready_r;
   logic                      wr_s;
   logic                      clr_s;
   logic [PHASE_W-1:0]        inc_sh_r  [NUM_CH];
   logic [PHASE_W-1:0]        off_sh_r  [NUM_CH];
   logic [PHASE_W-1:0]        inc_act_r [NUM_CH];
   logic [PHASE_W-1:0]        off_act_r [NUM_CH];
   logic [PHASE_W-1:0]        acc_r     [NUM_CH];
   logic [PHASE_W-1:0]        ph_s      [NUM_CH];
   logic [LUT_AW-1:0]         idx_s     [NUM_CH];
   logic [LUT_AW-1:0]         idx1_r    [NUM_CH];
   logic [LUT_AW-1:0]         sin_addr_r[NUM_CH];
   logic [LUT_AW-1:0]         cos_addr_r[NUM_CH];
   logic signed [OUT_W-1:0]   sin_d_r   [NUM_CH];
   logic signed [OUT_W-1:0]   cos_d_r   [NUM_CH];
   logic [NUM_CH-1:0]         v1_r;
   logic [NUM_CH-1:0]         v2_r;
   logic [NUM_CH-1:0]         v3_r;
   logic [NUM_CH-1:0]         valid_r;
   logic [NUM_CH*OUT_W-1:0]   sin_out_r;
   logic [NUM_CH*OUT_W-1:0]   cos_out_r;

   assign wr_s  = cfg_valid_i & cfg_ready_r;
   assign clr_s = commit_i & commit_clr_i;

`ifdef NCO_DITHER_EN
   localparam int          DW    = (SHIFT < 16) ? SHIFT : 16;
   localparam logic [15:0] DMASK = 16'((32'd1 << DW) - 32'd1);

   logic [15:0] lfsr_r;

   function automatic logic [15:0] rotl16(input logic [15:0] v, input int s);
      return (v << s) | (v >> (16 - s));
   endfunction

   // Free-running dither source, taps 16/14/13/11.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lfsr_r <= 16'hACE1;
      end else begin
         lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
      end
   end

   // Dithered phase: each channel sees the LFSR rotated by its index so channels decorrelate.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         ph_s[c] = acc_r[c] + off_act_r[c] + PHASE_W'(rotl16(lfsr_r, c % 16) & DMASK);
      end
   end
`else
   // Undithered phase: accumulator (pre-update) plus active offset.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         ph_s[c] = acc_r[c] + off_act_r[c];
      end
   end
`endif

   // LUT index is the top LUT_AW phase bits.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         idx_s[c] = LUT_AW'(ph_s[c] >> SHIFT);
      end
   end

   // Config shadow/active registers and phase accumulators.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cfg_ready_r <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            inc_sh_r[c]  <= '0;
            off_sh_r[c]  <= '0;
            inc_act_r[c] <= '0;
            off_act_r[c] <= '0;
            acc_r[c]     <= '0;
         end
      end else begin
         cfg_ready_r <= 1'b1;
         for (int c = 0; c < NUM_CH; c++) begin
            // Commit samples the pre-write shadow; a same-cycle write waits for the next commit.
            if (commit_i) begin
               inc_act_r[c] <= inc_sh_r[c];
               off_act_r[c] <= off_sh_r[c];
            end
            if (wr_s && (cfg_ch_i == CH_W'(c))) begin
               if (cfg_sel_i) begin
                  off_sh_r[c] <= cfg_data_i;
               end else begin
                  inc_sh_r[c] <= cfg_data_i;
               end
            end
            if (clr_s) begin
               acc_r[c] <= '0;
            end else if (en_i[c]) begin
               acc_r[c] <= acc_r[c] + inc_act_r[c];
            end
         end
      end
   end

   // Sample pipeline: index, ROM address, ROM data, output; valid bits travel alongside.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v1_r      <= '0;
         v2_r      <= '0;
         v3_r      <= '0;
         valid_r   <= '0;
         sin_out_r <= '0;
         cos_out_r <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            idx1_r[c]     <= '0;
            sin_addr_r[c] <= '0;
            cos_addr_r[c] <= '0;
            sin_d_r[c]    <= '0;
            cos_d_r[c]    <= '0;
         end
      end else begin
         v1_r    <= en_i;
         v2_r    <= v1_r;
         v3_r    <= v2_r;
         valid_r <= v3_r;
         for (int c = 0; c < NUM_CH; c++) begin
            idx1_r[c]     <= idx_s[c];
            sin_addr_r[c] <= idx1_r[c];
            cos_addr_r[c] <= idx1_r[c] + LUT_AW'(QTR);
            sin_d_r[c]    <= rom_s[sin_addr_r[c]];
            cos_d_r[c]    <= rom_s[cos_addr_r[c]];
            if (v3_r[c]) begin
               sin_out_r[c*OUT_W +: OUT_W] <= sin_d_r[c];
               cos_out_r[c*OUT_W +: OUT_W] <= cos_d_r[c];
            end
         end
      end
   end

   assign cfg_ready_o = cfg_ready_r;
   assign valid_o     = valid_r;
   assign sin_o       = sin_out_r;
   assign cos_o       = cos_out_r;

endmodule

// File: tb/tb_nco_bank.sv
// Self-checking bench for nco_bank (default build): reference model feeds a scoreboard queue of expected samples.
module tb_nco_bank;

   localparam int NUM_CH  = 4;
   localparam int PHASE_W = 32;
   localparam int OUT_W   = 16;
   localparam int LUT_AW  = 10;

   logic                    clk = 1'b0;
   logic                    rst_i;
   logic [NUM_CH-1:0]       en_i;
   logic                    cfg_valid_i;
   logic                    cfg_ready_o;
   logic [1:0]              cfg_ch_i;
   logic                    cfg_sel_i;
   logic [PHASE_W-1:0]      cfg_data_i;
   logic                    commit_i;
   logic                    commit_clr_i;
   logic [NUM_CH-1:0]       valid_o;
   logic [NUM_CH*OUT_W-1:0] sin_o;
   logic [NUM_CH*OUT_W-1:0] cos_o;

   always #5 clk = ~clk;

   nco_bank #(.NUM_CH(NUM_CH), .PHASE_W(PHASE_W), .OUT_W(OUT_W), .LUT_AW(LUT_AW)) dut (
      .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
      .cfg_ch_i(cfg_ch_i), .cfg_sel_i(cfg_sel_i), .cfg_data_i(cfg_data_i), .commit_i(commit_i),
      .commit_clr_i(commit_clr_i), .valid_o(valid_o), .sin_o(sin_o), .cos_o(cos_o)
   );

   typedef struct packed {
      logic [NUM_CH-1:0]       v;
      logic [NUM_CH*OUT_W-1:0] s;
      logic [NUM_CH*OUT_W-1:0] c;
   } row_t;

   row_t                    sb[$];
   logic [PHASE_W-1:0]      m_acc[NUM_CH], m_inc[NUM_CH], m_off[NUM_CH], m_inc_sh[NUM_CH], m_off_sh[NUM_CH];
   logic                    m_rdy;
   logic [NUM_CH-1:0]       exp_v;
   logic [NUM_CH*OUT_W-1:0] exp_s, exp_c;
   int                      n_checks, n_fail;

   function automatic logic [15:0] rom_ref(input int k);
      real x;
      int  r;
      x = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 1024.0);
      r = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
      return 16'(r);
   endfunction

   // One clock edge of the reference model; outputs are compared by the callers at edge + 1.
   task automatic tick();
      row_t               r;
      logic [PHASE_W-1:0] ph;
      int                 idx;
      @(posedge clk);
      if (rst_i) begin
         for (int c = 0; c < NUM_CH; c++) begin
            m_acc[c] = '0; m_inc[c] = '0; m_off[c] = '0; m_inc_sh[c] = '0; m_off_sh[c] = '0;
         end
         sb.delete();
         m_rdy = 1'b0; exp_v = '0; exp_s = '0; exp_c = '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            ph  = m_acc[c] + m_off[c];
            idx = int'(ph[PHASE_W-1 -: LUT_AW]);
            r.v[c] = en_i[c];
            r.s[c*OUT_W +: OUT_W] = rom_ref(idx);
            r.c[c*OUT_W +: OUT_W] = rom_ref((idx + 256) % 1024);
         end
         sb.push_back(r);
         if (sb.size() == 4) begin
            r = sb.pop_front();
            exp_v = r.v;
            for (int c = 0; c < NUM_CH; c++) begin
               if (r.v[c]) begin
                  exp_s[c*OUT_W +: OUT_W] = r.s[c*OUT_W +: OUT_W];
                  exp_c[c*OUT_W +: OUT_W] = r.c[c*OUT_W +: OUT_W];
               end
            end
         end
         for (int c = 0; c < NUM_CH; c++) begin
            if (commit_i && commit_clr_i) m_acc[c] = '0;
            else if (en_i[c]) m_acc[c] = m_acc[c] + m_inc[c];
            if (commit_i) begin
               m_inc[c] = m_inc_sh[c];
               m_off[c] = m_off_sh[c];
            end
         end
         if (cfg_valid_i && m_rdy && int'(cfg_ch_i) < NUM_CH) begin
            if (cfg_sel_i) m_off_sh[cfg_ch_i] = cfg_data_i;
            else m_inc_sh[cfg_ch_i] = cfg_data_i;
         end
         m_rdy = 1'b1;
      end
      #1;
   endtask

   task automatic drive_cfg(input logic wr, input int ch, input logic sel, input logic [31:0] data,
                            input logic cm, input logic clr);
      cfg_valid_i = wr; cfg_ch_i = 2'(ch); cfg_sel_i = sel; cfg_data_i = data;
      commit_i = cm; commit_clr_i = clr;
      tick();
      cfg_valid_i = 1'b0; commit_i = 1'b0; commit_clr_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; en_i = 4'hF;
      repeat (4) tick();
      n_checks++; if (valid_o !== 4'h0) begin n_fail++; $display("FAIL reset_valid got %h expected 0", valid_o); end
      n_checks++; if (sin_o !== 64'h0) begin n_fail++; $display("FAIL reset_sin got %h expected 0", sin_o); end
      n_checks++; if (cos_o !== 64'h0) begin n_fail++; $display("FAIL reset_cos got %h expected 0", cos_o); end
      n_checks++; if (cfg_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b expected 0", cfg_ready_o); end
      rst_i = 1'b0; en_i = 4'h0;
      tick();
      n_checks++; if (cfg_ready_o !== 1'b1) begin n_fail++; $display("FAIL release_ready got %b expected 1", cfg_ready_o); end
      n_checks++; if (valid_o !== 4'h0) begin n_fail++; $display("FAIL release_valid got %h expected 0", valid_o); end
   endtask

   task automatic test_quarter_step();
      logic [15:0] qs[4];
      logic [15:0] qc[4];
      qs = '{16'h0000, 16'h7FFF, 16'h0000, 16'h8001};
      qc = '{16'h7FFF, 16'h0000, 16'h8001, 16'h0000};
      drive_cfg(1'b1, 0, 1'b0, 32'h4000_0000, 1'b0, 1'b0);
      drive_cfg(1'b0, 0, 1'b0, 32'h0, 1'b1, 1'b1);
      en_i = 4'b0001;
      for (int k = 0; k < 12; k++) begin
         tick();
         for (int c = 0; c < NUM_CH; c++) begin
            n_checks++;
            if ({valid_o[c], sin_o[c*OUT_W +: OUT_W], cos_o[c*OUT_W +: OUT_W]} !==
                {exp_v[c], exp_s[c*OUT_W +: OUT_W], exp_c[c*OUT_W +: OUT_W]}) begin
               n_fail++;
               $display("FAIL quarter_model ch%0d k=%0d got v=%b s=%0d c=%0d expected v=%b s=%0d c=%0d", c, k,
                        valid_o[c], $signed(sin_o[c*OUT_W +: OUT_W]), $signed(cos_o[c*OUT_W +: OUT_W]),
                        exp_v[c], $signed(exp_s[c*OUT_W +: OUT_W]), $signed(exp_c[c*OUT_W +: OUT_W]));
            end
         end
         n_checks++;
         if (k < 3) begin
            if (valid_o[0] !== 1'b0) begin n_fail++; $display("FAIL quarter_latency k=%0d got valid %b expected 0", k, valid_o[0]); end
         end else if ({valid_o[0], sin_o[15:0], cos_o[15:0]} !== {1'b1, qs[(k-3)%4], qc[(k-3)%4]}) begin
            n_fail++;
            $display("FAIL quarter_seq k=%0d got v=%b s=%h c=%h expected v=1 s=%h c=%h", k, valid_o[0],
                     sin_o[15:0], cos_o[15:0], qs[(k-3)%4], qc[(k-3)%4]);
         end
      end
   endtask

   task automatic test_offset_isolation();
      drive_cfg(1'b1, 2, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
      drive_cfg(1'b0, 0, 1'b0, 32'h0, 1'b1, 1'b0);
      en_i = 4'b0101;
      for (int k = 0; k < 10; k++) begin
         tick();
         for (int c = 0; c < NUM_CH; c++) begin
            n_checks++;
            if ({valid_o[c], sin_o[c*OUT_W +: OUT_W], cos_o[c*OUT_W +: OUT_W]} !==
                {exp_v[c], exp_s[c*OUT_W +: OUT_W], exp_c[c*OUT_W +: OUT_W]}) begin
               n_fail++;
               $display("FAIL offset_model ch%0d k=%0d got v=%b s=%0d c=%0d expected v=%b s=%0d c=%0d", c, k,
                        valid_o[c], $signed(sin_o[c*OUT_W +: OUT_W]), $signed(cos_o[c*OUT_W +: OUT_W]),
                        exp_v[c], $signed(exp_s[c*OUT_W +: OUT_W]), $signed(exp_c[c*OUT_W +: OUT_W]));
            end
         end
         n_checks++;
         if ({valid_o[3], valid_o[1]} !== 2'b00) begin n_fail++; $display("FAIL offset_isolation k=%0d got v3v1=%b%b expected 00", k, valid_o[3], valid_o[1]); end
         if (k >= 3) begin
            n_checks++;
            if ({valid_o[2], sin_o[47:32], cos_o[47:32]} !== {1'b1, 16'h0000, 16'h8001}) begin
               n_fail++;
               $display("FAIL offset_ch2 k=%0d got v=%b s=%h c=%h expected v=1 s=0000 c=8001", k, valid_o[2], sin_o[47:32], cos_o[47:32]);
            end
         end
      end
   endtask

   task automatic test_shadow();
      logic saw8;
      en_i = 4'b0010;
      drive_cfg(1'b1, 1, 1'b0, 32'h2000_0000, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         tick();
         if (k >= 3) begin
            n_checks++;
            if ({valid_o[1], sin_o[31:16], cos_o[31:16]} !== {1'b1, 16'h0000, 16'h7FFF}) begin
               n_fail++;
               $display("FAIL shadow_nocommit k=%0d got v=%b s=%h c=%h expected v=1 s=0000 c=7fff", k, valid_o[1], sin_o[31:16], cos_o[31:16]);
            end
         end
      end
      drive_cfg(1'b1, 1, 1'b0, 32'h4000_0000, 1'b1, 1'b0);
      saw8 = 1'b0;
      for (int k = 0; k < 18; k++) begin
         if (k == 9) drive_cfg(1'b0, 0, 1'b0, 32'h0, 1'b1, 1'b0);
         else tick();
         if (k < 9 && valid_o[1] && sin_o[31:16] == 16'h5A82) saw8 = 1'b1;
         for (int c = 0; c < NUM_CH; c++) begin
            n_checks++;
            if ({valid_o[c], sin_o[c*OUT_W +: OUT_W], cos_o[c*OUT_W +: OUT_W]} !==
                {exp_v[c], exp_s[c*OUT_W +: OUT_W], exp_c[c*OUT_W +: OUT_W]}) begin
               n_fail++;
               $display("FAIL shadow_model ch%0d k=%0d got v=%b s=%0d c=%0d expected v=%b s=%0d c=%0d", c, k,
                        valid_o[c], $signed(sin_o[c*OUT_W +: OUT_W]), $signed(cos_o[c*OUT_W +: OUT_W]),
                        exp_v[c], $signed(exp_s[c*OUT_W +: OUT_W]), $signed(exp_c[c*OUT_W +: OUT_W]));
            end
         end
      end
      n_checks++;
      if (saw8 !== 1'b1) begin n_fail++; $display("FAIL shadow_old_value got eighth_step_seen=%b expected 1", saw8); end
   endtask

   task automatic test_wrap_hold();
      logic [15:0] ws[4];
      logic [11:0] pat;
      ws  = '{16'h0000, 16'h8001, 16'h0000, 16'h7FFF};
      pat = 12'b0110_0101_1101;
      en_i = 4'b0000;
      drive_cfg(1'b1, 3, 1'b0, 32'hC000_0000, 1'b0, 1'b0);
      drive_cfg(1'b0, 0, 1'b0, 32'h0, 1'b1, 1'b1);
      en_i = 4'b1000;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (k >= 3) begin
            n_checks++;
            if ({valid_o[3], sin_o[63:48]} !== {1'b1, ws[(k-3)%4]}) begin
               n_fail++;
               $display("FAIL wrap_seq k=%0d got v=%b s=%h expected v=1 s=%h", k, valid_o[3], sin_o[63:48], ws[(k-3)%4]);
            end
         end
      end
      for (int k = 0; k < 12; k++) begin
         en_i = {pat[k], 3'b000};
         tick();
         for (int c = 0; c < NUM_CH; c++) begin
            n_checks++;
            if ({valid_o[c], sin_o[c*OUT_W +: OUT_W], cos_o[c*OUT_W +: OUT_W]} !==
                {exp_v[c], exp_s[c*OUT_W +: OUT_W], exp_c[c*OUT_W +: OUT_W]}) begin
               n_fail++;
               $display("FAIL hold_model ch%0d k=%0d got v=%b s=%0d c=%0d expected v=%b s=%0d c=%0d", c, k,
                        valid_o[c], $signed(sin_o[c*OUT_W +: OUT_W]), $signed(cos_o[c*OUT_W +: OUT_W]),
                        exp_v[c], $signed(exp_s[c*OUT_W +: OUT_W]), $signed(exp_c[c*OUT_W +: OUT_W]));
            end
         end
         if (k >= 3) begin
            n_checks++;
            if (valid_o[3] !== pat[k-3]) begin n_fail++; $display("FAIL hold_valid k=%0d got %b expected %b", k, valid_o[3], pat[k-3]); end
         end
      end
   endtask

   task automatic test_back_to_back();
      en_i = 4'h0;
      drive_cfg(1'b1, 0, 1'b0, 32'h0123_4567, 1'b0, 1'b0);
      drive_cfg(1'b1, 1, 1'b0, 32'h1000_0000, 1'b0, 1'b0);
      drive_cfg(1'b1, 2, 1'b0, 32'hFFF0_0000, 1'b0, 1'b0);
      drive_cfg(1'b1, 3, 1'b0, 32'h0800_0001, 1'b0, 1'b0);
      drive_cfg(1'b1, 0, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
      drive_cfg(1'b0, 0, 1'b0, 32'h0, 1'b1, 1'b1);
      for (int k = 0; k < 40; k++) begin
         en_i = (k < 20) ? 4'hF : 4'($urandom_range(0, 15));
         tick();
         for (int c = 0; c < NUM_CH; c++) begin
            n_checks++;
            if ({valid_o[c], sin_o[c*OUT_W +: OUT_W], cos_o[c*OUT_W +: OUT_W]} !==
                {exp_v[c], exp_s[c*OUT_W +: OUT_W], exp_c[c*OUT_W +: OUT_W]}) begin
               n_fail++;
               $display("FAIL b2b_model ch%0d k=%0d got v=%b s=%0d c=%0d expected v=%b s=%0d c=%0d", c, k,
                        valid_o[c], $signed(sin_o[c*OUT_W +: OUT_W]), $signed(cos_o[c*OUT_W +: OUT_W]),
                        exp_v[c], $signed(exp_s[c*OUT_W +: OUT_W]), $signed(exp_c[c*OUT_W +: OUT_W]));
            end
         end
      end
   endtask

   task automatic test_midrun_reset();
      en_i = 4'hF;
      repeat (4) tick();
      rst_i = 1'b1;
      tick();
      n_checks++; if (valid_o !== 4'h0) begin n_fail++; $display("FAIL midreset_valid got %h expected 0", valid_o); end
      n_checks++; if (cfg_ready_o !== 1'b0) begin n_fail++; $display("FAIL midreset_ready got %b expected 0", cfg_ready_o); end
      rst_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_checks++;
         if (k < 3) begin
            if (valid_o !== 4'h0) begin n_fail++; $display("FAIL midreset_flush k=%0d got %h expected 0", k, valid_o); end
         end else if ({valid_o, sin_o, cos_o} !== {4'hF, 64'h0, {4{16'h7FFF}}}) begin
            n_fail++;
            $display("FAIL midreset_restart got v=%h s=%h c=%h expected v=f s=0 c=7fff x4", valid_o, sin_o, cos_o);
         end
      end
   endtask

   initial begin
      rst_i = 1'b1; en_i = '0; cfg_valid_i = 1'b0; cfg_ch_i = '0; cfg_sel_i = 1'b0;
      cfg_data_i = '0; commit_i = 1'b0; commit_clr_i = 1'b0;
      m_rdy = 1'b0; exp_v = '0; exp_s = '0; exp_c = '0;
      n_checks = 0; n_fail = 0;
      test_reset();
      test_quarter_step();
      test_offset_isolation();
      test_shadow();
      test_wrap_hold();
      test_back_to_back();
      test_midrun_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
